fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 63 ++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: fetches words from a 1-cycle-latency FIFO into a 2-entry
// in-order buffer and presents them as a valid/ready stream with a delivery count.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  empty,
  input  logic                  underflow,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  clear_err,
  output logic                  err_underflow,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] buf0, buf1, buf0_nx, buf1_nx;
  logic [1:0] occ, level;
  logic inflight, pop, wr_head, wr_tail;
  always_comb begin
    state_nx = state;
    pop = (occ != 2'd0) && m_ready;
    level = occ + {1'b0, inflight} - {1'b0, pop};
    // level counts words held after this edge, including the one landing now
    read_en = (state == RUN) && !empty && (level < 2'd2);
    wr_head = inflight && (occ == {1'b0, pop});
    wr_tail = inflight && !wr_head;
    buf0_nx = wr_head ? data_out : (pop ? buf1 : buf0);
    buf1_nx = wr_tail ? data_out : buf1;
    if (enable) state_nx = RUN;
    else if (state == RUN) state_nx = DRAIN;
    else if (state == DRAIN && occ == 2'd0 && !inflight) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      occ <= 2'd0;
      inflight <= 1'b0;
      buf0 <= '0;
      buf1 <= '0;
      rd_count <= '0;
      err_underflow <= 1'b0;
    end else begin
      state <= state_nx;
      occ <= level;
      inflight <= read_en;
      buf0 <= buf0_nx;
      buf1 <= buf1_nx;
      rd_count <= rd_count + {{(CNT_WIDTH-1){1'b0}}, pop};
      err_underflow <= underflow || (err_underflow && !clear_err);
    end
  end
  assign m_valid = (occ != 2'd0);
  assign m_data = buf0;
  assign busy = (state != IDLE);
endmodule
